// File: rtl/comm_recv_demap.sv
// comm_recv_demap: BPSK hard-decision demapper packing data-bin bits LSB-first into 128-bit FIFO words.
// Optional low-magnitude decision counter enabled by defining COMM_RECV_LOWMAG_EN.
module comm_recv_demap #(
    parameter int width     = 11,
    parameter int FIRST_BIN = 1,
    parameter int NBINS     = 32,
    parameter int LOWMAG    = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    valid_i,
    input  logic                    sop_i,
    input  logic signed [width-1:0] xr,
    input  logic signed [width-1:0] xi,
    output logic                    wr_en,
    output logic [127:0]            dout,
    input  logic                    full,
    output logic                    valid_raw,
    output logic [5:0]              raw,
    output logic                    overflow,
    output logic [15:0]             lowmag_cnt
);
    localparam logic [6:0] LO = 7'(FIRST_BIN);
    localparam logic [6:0] HI = 7'(FIRST_BIN + NBINS - 1);

    logic [5:0]   bin_q, bin_d, idx;
    logic [6:0]   cnt_q, cnt_d;
    logic [127:0] sreg_q, sreg_d, dout_q, dout_d, word;
    logic         pending_q, pending_d, overflow_q, overflow_d;
    logic         valid_raw_q, valid_raw_d, raw_q, raw_d;
    logic         is_data, dbit, done, take;
    logic         unused_ok;

    assign wr_en     = pending_q & ~full;
    assign dout      = dout_q;
    assign valid_raw = valid_raw_q;
    assign raw       = {5'd0, raw_q};
    assign overflow  = overflow_q;

    always_comb begin
        idx         = sop_i ? 6'd0 : bin_q;
        is_data     = valid_i && {1'b0, idx} >= LO && {1'b0, idx} <= HI;
        dbit        = ~xr[width-1];
        word        = sreg_q;
        word[cnt_q] = dbit;
        done        = is_data && cnt_q == 7'd127;
        // A completed word may replace the pending one only if that one leaves this cycle
        take        = done && (!pending_q || wr_en);
        bin_d       = valid_i ? idx + 6'd1 : bin_q;
        cnt_d       = is_data ? cnt_q + 7'd1 : cnt_q;
        sreg_d      = is_data ? word : sreg_q;
        dout_d      = take ? word : dout_q;
        pending_d   = take | (pending_q & ~wr_en);
        overflow_d  = overflow_q | (done & ~take);
        valid_raw_d = is_data;
        raw_d       = is_data ? dbit : raw_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bin_q       <= '0;
            cnt_q       <= '0;
            sreg_q      <= '0;
            dout_q      <= '0;
            pending_q   <= 1'b0;
            overflow_q  <= 1'b0;
            valid_raw_q <= 1'b0;
            raw_q       <= 1'b0;
        end else begin
            bin_q       <= bin_d;
            cnt_q       <= cnt_d;
            sreg_q      <= sreg_d;
            dout_q      <= dout_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            valid_raw_q <= valid_raw_d;
            raw_q       <= raw_d;
        end
    end

`ifdef COMM_RECV_LOWMAG_EN
    logic [15:0]  lowmag_q, lowmag_d;
    logic [width:0] mag;

    assign lowmag_cnt = lowmag_q;
    assign unused_ok  = ^xi;

    always_comb begin
        // One extra bit so the most negative sample has a representable magnitude
        mag      = xr[width-1] ? -{xr[width-1], xr} : {xr[width-1], xr};
        lowmag_d = (is_data && int'(mag) < LOWMAG && lowmag_q != 16'hFFFF) ? lowmag_q + 16'd1 : lowmag_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) lowmag_q <= '0;
        else     lowmag_q <= lowmag_d;
    end
`else
    assign lowmag_cnt = 16'd0;
    assign unused_ok  = ^xi ^ (LOWMAG > 0);
`endif
endmodule

// File: tb/tb_comm_recv_demap.sv
// tb_comm_recv_demap: directed table plus frame sequences for comm_recv_demap.
module tb_comm_recv_demap;
    localparam int W = 11;

    logic          CLK = 1'b0, RST = 1'b1, valid_i = 1'b0, sop_i = 1'b0, full = 1'b0;
    logic [W-1:0]  xr = '0, xi = '0;
    logic          wr_en, valid_raw, overflow;
    logic [127:0]  dout;
    logic [5:0]    raw;
    logic [15:0]   lowmag_cnt;

    int checks = 0, failures = 0;
    int sent, vr_cnt, wr_cnt, pulse_at;
    logic [127:0] last_dout;

    localparam logic [127:0] ONES = '1;
    localparam logic [127:0] ALT  = {32{4'h5}};

    comm_recv_demap dut (
        .CLK(CLK), .RST(RST), .valid_i(valid_i), .sop_i(sop_i), .xr(xr), .xi(xi),
        .wr_en(wr_en), .dout(dout), .full(full), .valid_raw(valid_raw), .raw(raw),
        .overflow(overflow), .lowmag_cnt(lowmag_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic v;
        logic s;
        int   x;
        logic evr;
        logic eraw;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic v, input logic s, input int x);
        valid_i = v;
        sop_i   = s;
        xr      = x[W-1:0];
        xi      = ~x[W-1:0];
        @(posedge CLK);
        #1;
        sent++;
        if (valid_raw) vr_cnt++;
        if (wr_en) begin
            wr_cnt++;
            last_dout = dout;
            if (pulse_at == 0) pulse_at = sent;
        end
    endtask

    task automatic do_reset();
        RST     = 1'b1;
        valid_i = 1'b1;
        sop_i   = 1'b0;
        xr      = 11'd100;
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        valid_i  = 1'b0;
        sent     = 0;
        vr_cnt   = 0;
        wr_cnt   = 0;
        pulse_at = 0;
    endtask

    // mode 0: all data bins positive; mode 1: odd bins positive, even bins negative
    task automatic frame(input int mode);
        for (int i = 0; i < 64; i++)
            send(1'b1, i == 0, (i >= 1 && i <= 32) ? ((mode == 0 || i % 2 == 1) ? 100 : -100) : -100);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"}, 128'(wr_en), 128'd0);
        chk({tag, "_dout"}, dout, 128'd0);
        chk({tag, "_valid_raw"}, 128'(valid_raw), 128'd0);
        chk({tag, "_raw"}, 128'(raw), 128'd0);
        chk({tag, "_overflow"}, 128'(overflow), 128'd0);
        chk({tag, "_lowmag"}, 128'(lowmag_cnt), 128'd0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1,   100, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0,   100, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b0,    -1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0,    -1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0,     0, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, -1024, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b1,   -50, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0,   -50, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 1'b0,     7, 1'b1, 1'b1};

        do_reset();
        chk_zero("init");

        for (int i = 0; i < 9; i++) begin
            send(tbl[i].v, tbl[i].s, tbl[i].x);
            chk($sformatf("vec%0d_valid_raw", i), 128'(valid_raw), 128'(tbl[i].evr));
            if (tbl[i].evr) chk($sformatf("vec%0d_raw", i), 128'(raw), {122'd0, 5'd0, tbl[i].eraw});
        end

        do_reset();
        for (int f = 0; f < 4; f++) frame(0);
        chk("ones_wr_count", 128'(wr_cnt), 128'd1);
        chk("ones_pulse_pos", 128'(pulse_at), 128'd225);
        chk("ones_dout", last_dout, ONES);
        chk("ones_vr_count", 128'(vr_cnt), 128'd128);

        do_reset();
        for (int f = 0; f < 4; f++) frame(1);
        chk("alt_wr_count", 128'(wr_cnt), 128'd1);
        chk("alt_dout", last_dout, ALT);
        chk("alt_vr_count", 128'(vr_cnt), 128'd128);

        do_reset();
        full = 1'b1;
        for (int f = 0; f < 4; f++) frame(1);
        chk("full1_wr_en", 128'(wr_en), 128'd0);
        chk("full1_overflow", 128'(overflow), 128'd0);
        chk("full1_dout", dout, ALT);
        for (int f = 0; f < 4; f++) frame(0);
        chk("full2_wr_count", 128'(wr_cnt), 128'd0);
        chk("full2_overflow", 128'(overflow), 128'd1);
        chk("full2_dout", dout, ALT);
        full = 1'b0;
        #1;
        chk("release_wr_en", 128'(wr_en), 128'd1);
        chk("release_dout", dout, ALT);
        send(1'b0, 1'b0, 0);
        chk("release_drained", 128'(wr_en), 128'd0);
        chk("release_overflow_sticky", 128'(overflow), 128'd1);
        send(1'b0, 1'b0, 0);
        chk("release_single_pulse", 128'(wr_en), 128'd0);

        send(1'b1, 1'b1, 100);
        for (int i = 1; i < 6; i++) send(1'b1, 1'b0, 100);
        do_reset();
        chk_zero("midrst");
        send(1'b1, 1'b0, 100);
        chk("midrst_bin0_no_bit", 128'(valid_raw), 128'd0);
        send(1'b1, 1'b0, 100);
        chk("midrst_bin1_bit", 128'(valid_raw), 128'd1);

        do_reset();
        send(1'b1, 1'b1, 100);
        for (int i = 1; i < 20; i++) send(1'b1, 1'b0, 100);
        send(1'b1, 1'b1, 100);
        chk("resync_sop_no_bit", 128'(valid_raw), 128'd0);
        send(1'b1, 1'b0, -100);
        chk("resync_bin1_vr", 128'(valid_raw), 128'd1);
        chk("resync_bin1_raw", 128'(raw), 128'd0);
        for (int i = 2; i < 64; i++) send(1'b1, 1'b0, i <= 32 ? 100 : -100);
        frame(0);
        frame(0);
        send(1'b1, 1'b1, -100);
        for (int i = 1; i <= 13; i++) send(1'b1, 1'b0, 100);
        chk("resync_wr_en_now", 128'(wr_en), 128'd1);
        chk("resync_wr_count", 128'(wr_cnt), 128'd1);
        chk("resync_dout", last_dout, ~(128'd1 << 19));

        do_reset();
        send(1'b1, 1'b1, -100);
        for (int i = 1; i <= 10; i++) send(1'b1, 1'b0, 5);
        for (int i = 11; i <= 20; i++) send(1'b1, 1'b0, -100);
`ifdef COMM_RECV_LOWMAG_EN
        chk("lowmag_cnt", 128'(lowmag_cnt), 128'd10);
`else
        chk("lowmag_cnt", 128'(lowmag_cnt), 128'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
